// File: rtl/shader_instruction_fetch.sv
// Vertex shader instruction fetch: PC, 1-cycle instruction memory reads, 2-deep issue buffer, branch flush, END stop.
// Optional performance counters are enabled with `define SHADER_IF_PERF_EN.
module shader_instruction_fetch #(
    parameter int                       INSTR_W = 32,
    parameter int                       PC_W    = 10,
    parameter int                       OPC_MSB = 31,
    parameter int                       OPC_LSB = 26,
    parameter logic [OPC_MSB-OPC_LSB:0] OPC_END = 6'h3F
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               iStart,
    input  logic [PC_W-1:0]    iStartPC,
    output logic               oIMemRd,
    output logic [PC_W-1:0]    oIMemAddr,
    input  logic [INSTR_W-1:0] iIMemData,
    output logic               oValid,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [PC_W-1:0]    oPC,
    input  logic               iReady,
    input  logic               iBranchValid,
    input  logic [PC_W-1:0]    iBranchTarget,
    output logic               oBusy,
`ifdef SHADER_IF_PERF_EN
    output logic [15:0]        oPerfFetchCnt,
    output logic [15:0]        oPerfStallCnt,
`endif
    output logic               oDone
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic is_end(input logic [INSTR_W-1:0] word);
        return (word[OPC_MSB:OPC_LSB] == OPC_END);
    endfunction

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic [PC_W-1:0]    pc_q;
    logic               epoch_q;
    logic               inflight_q;
    logic               inflight_epoch_q;
    logic [PC_W-1:0]    inflight_pc_q;
    logic [INSTR_W-1:0] word_q [2];
    logic [PC_W-1:0]    word_pc_q [2];
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         count_q;
    logic [1:0]         count_d;

    logic               start_s;
    logic               pop_s;
    logic               end_pop_s;
    logic               branch_s;
    logic               push_s;
    logic               push_end_s;
    logic [2:0]         occ_s;
    logic               rd_s;

    assign start_s    = iStart && (state_q == ST_IDLE);
    assign pop_s      = (count_q != 2'd0) && iReady;
    assign end_pop_s  = pop_s && is_end(word_q[rd_ptr_q]);
    // An END handed to decode in DRAIN finishes the program even if a redirect arrives with it.
    assign branch_s   = iBranchValid &&
                        ((state_q == ST_RUN) || ((state_q == ST_DRAIN) && !end_pop_s));
    assign push_s     = inflight_q && (inflight_epoch_q == epoch_q) &&
                        (state_q == ST_RUN) && !branch_s;
    assign push_end_s = push_s && is_end(iIMemData);
    // Occupancy after this cycle's pop, so a steady stream issues one read per cycle.
    assign occ_s      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign rd_s       = (state_q == ST_RUN) && !branch_s && (occ_s < 3'd2);

    assign oIMemRd      = rd_s;
    assign oIMemAddr    = pc_q;
    assign oValid       = (count_q != 2'd0);
    assign oInstruction = word_q[rd_ptr_q];
    assign oPC          = word_pc_q[rd_ptr_q];
    assign oBusy        = busy_q;
    assign oDone        = done_q;

    // Buffer occupancy next-state.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + 2'd1;
        end else if (pop_s && !push_s) begin
            count_d = count_q - 2'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Program control FSM with registered busy/done flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_s) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    done_q <= 1'b0;
                    if (branch_s) begin
                        state_q <= ST_RUN;
                    end else if (push_end_s) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (end_pop_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (branch_s) begin
                        state_q <= ST_RUN;
                        done_q  <= 1'b0;
                    end else begin
                        done_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // PC, read tracking and the two-entry issue buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q             <= '0;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            inflight_pc_q    <= '0;
            rd_ptr_q         <= 1'b0;
            wr_ptr_q         <= 1'b0;
            count_q          <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                word_q[i]    <= '0;
                word_pc_q[i] <= '0;
            end
        end else begin
            inflight_q <= rd_s;
            if (rd_s) begin
                inflight_epoch_q <= epoch_q;
                inflight_pc_q    <= pc_q;
            end
            if (start_s) begin
                pc_q     <= iStartPC;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                count_q  <= 2'd0;
            end else if (branch_s) begin
                pc_q     <= iBranchTarget;
                epoch_q  <= ~epoch_q;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                count_q  <= 2'd0;
            end else begin
                if (rd_s) begin
                    pc_q <= pc_q + PC_W'(1);
                end
                if (push_s) begin
                    word_q[wr_ptr_q]    <= iIMemData;
                    word_pc_q[wr_ptr_q] <= inflight_pc_q;
                    wr_ptr_q            <= ~wr_ptr_q;
                end
                if (pop_s) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                count_q <= count_d;
            end
        end
    end

`ifdef SHADER_IF_PERF_EN
    logic [15:0] perf_fetch_q;
    logic [15:0] perf_stall_q;

    assign oPerfFetchCnt = perf_fetch_q;
    assign oPerfStallCnt = perf_stall_q;

    // Saturating transfer and stall counters, cleared when a program starts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetch_q <= 16'h0000;
            perf_stall_q <= 16'h0000;
        end else if (start_s) begin
            perf_fetch_q <= 16'h0000;
            perf_stall_q <= 16'h0000;
        end else begin
            if (pop_s && (perf_fetch_q != 16'hFFFF)) begin
                perf_fetch_q <= perf_fetch_q + 16'h0001;
            end
            if (oValid && !iReady && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shader_instruction_fetch.sv
// Scoreboard bench for shader_instruction_fetch: straight line, backpressure, branch, PC wrap, reset mid-run.
module tb_shader_instruction_fetch;

    localparam int PC_W    = 5;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] w;
    } exp_t;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               iStart = 1'b0;
    logic [PC_W-1:0]    iStartPC = '0;
    logic               oIMemRd;
    logic [PC_W-1:0]    oIMemAddr;
    logic [INSTR_W-1:0] rdata = '0;
    logic               oValid;
    logic [INSTR_W-1:0] oInstruction;
    logic [PC_W-1:0]    oPC;
    logic               iReady = 1'b1;
    logic               iBranchValid = 1'b0;
    logic [PC_W-1:0]    iBranchTarget = '0;
    logic               oBusy;
    logic               oDone;
`ifdef SHADER_IF_PERF_EN
    logic [15:0]        oPerfFetchCnt;
    logic [15:0]        oPerfStallCnt;
`endif

    logic [INSTR_W-1:0] mem [32];
    exp_t               exp_q [$];
    int                 vec_cnt = 0;
    int                 miscmp_cnt = 0;
    int                 rd_cnt = 0;
    int                 xfer_cnt = 0;
    bit                 chk_out = 1'b0;

    localparam logic [INSTR_W-1:0] W_A    = 32'h1000_00A1;
    localparam logic [INSTR_W-1:0] W_B    = 32'h1400_00B2;
    localparam logic [INSTR_W-1:0] W_C    = 32'h1800_00C3;
    localparam logic [INSTR_W-1:0] W_END  = 32'hFC00_0007;
    localparam logic [INSTR_W-1:0] W_D    = 32'h2000_00D4;
    localparam logic [INSTR_W-1:0] W_END2 = 32'hFC00_0015;
    localparam logic [INSTR_W-1:0] W_X    = 32'h2400_00E5;
    localparam logic [INSTR_W-1:0] W_END3 = 32'hFC00_0000;

    shader_instruction_fetch #(.INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .iStart        (iStart),
        .iStartPC      (iStartPC),
        .oIMemRd       (oIMemRd),
        .oIMemAddr     (oIMemAddr),
        .iIMemData     (rdata),
        .oValid        (oValid),
        .oInstruction  (oInstruction),
        .oPC           (oPC),
        .iReady        (iReady),
        .iBranchValid  (iBranchValid),
        .iBranchTarget (iBranchTarget),
        .oBusy         (oBusy),
`ifdef SHADER_IF_PERF_EN
        .oPerfFetchCnt (oPerfFetchCnt),
        .oPerfStallCnt (oPerfStallCnt),
`endif
        .oDone         (oDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (oIMemRd) rdata <= mem[oIMemAddr];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] w);
        exp_t e;
        e.pc = pc;
        e.w  = w;
        exp_q.push_back(e);
    endtask

    // Monitor: scoreboard compare on every transfer, plus hold, done and outstanding-read checks.
    initial begin
        bit                 end_prev = 1'b0;
        bit                 hold_prev = 1'b0;
        bit                 br_prev = 1'b0;
        logic [INSTR_W-1:0] hold_word = '0;
        logic [INSTR_W-1:0] ew;
        exp_t               e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                end_prev  = 1'b0;
                hold_prev = 1'b0;
            end else begin
                check_eq("done", 64'(oDone), 64'(end_prev));
                end_prev = 1'b0;
                if (hold_prev && !br_prev) begin
                    check_eq("hold_valid", 64'(oValid), 64'd1);
                    check_eq("hold_instr", 64'(oInstruction), 64'(hold_word));
                end
                if (oIMemRd) rd_cnt++;
                if (oValid && iReady) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_word", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e  = exp_q.pop_front();
                        ew = e.w;
                        check_eq("instr", 64'(oInstruction), 64'(ew));
                        check_eq("pc", 64'(oPC), 64'(e.pc));
                        end_prev = (ew[31:26] == 6'h3F);
                    end
                end
                if (chk_out) check_eq("outstanding", 64'((rd_cnt - xfer_cnt) <= 2), 64'd1);
                hold_prev = oValid && !iReady;
                hold_word = oInstruction;
                br_prev   = iBranchValid;
            end
        end
    end

    task automatic start_prog(input logic [PC_W-1:0] pc);
        @(posedge clk); #1;
        iStart   = 1'b1;
        iStartPC = pc;
        @(posedge clk); #1;
        iStart   = 1'b0;
    endtask

    task automatic run(input int st_from, input int st_to, input int br_at,
                       input logic [PC_W-1:0] tgt, input bit chk_lat);
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            iReady        = !(i >= st_from && i <= st_to);
            iBranchValid  = (i == br_at);
            iBranchTarget = tgt;
            if (chk_lat && i == 1) check_eq("latency_c1", 64'(oValid), 64'd0);
            if (chk_lat && i == 2) check_eq("latency_c2", 64'(oValid), 64'd1);
            if (br_at > 0 && i == br_at + 1) check_eq("br_flush", 64'(oValid), 64'd0);
            if (!oBusy && exp_q.size() == 0 && i > br_at + 1) break;
        end
        iReady       = 1'b1;
        iBranchValid = 1'b0;
        check_eq("end_busy", 64'(oBusy), 64'd0);
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {6'h01, 26'(i)};
        mem[4]  = W_A;   mem[5]  = W_B;    mem[6] = W_C; mem[7] = W_END;
        mem[20] = W_D;   mem[21] = W_END2;
        mem[31] = W_X;   mem[0]  = W_END3;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(oValid), 64'd0);
        check_eq("rst_busy", 64'(oBusy), 64'd0);
        check_eq("rst_done", 64'(oDone), 64'd0);
        check_eq("rst_rd", 64'(oIMemRd), 64'd0);
        check_eq("rst_addr", 64'(oIMemAddr), 64'd0);
        check_eq("rst_pc", 64'(oPC), 64'd0);
        check_eq("rst_instr", 64'(oInstruction), 64'd0);
        resetn = 1'b1;

        // Straight line
        push_exp(5'd4, W_A); push_exp(5'd5, W_B); push_exp(5'd6, W_C); push_exp(5'd7, W_END);
        start_prog(5'd4);
        check_eq("latency_c0", 64'(oValid), 64'd0);
        run(0, -1, -1, 5'd0, 1'b1);

        // Backpressure
        push_exp(5'd4, W_A); push_exp(5'd5, W_B); push_exp(5'd6, W_C); push_exp(5'd7, W_END);
        chk_out  = 1'b1;
        rd_cnt   = 0;
        xfer_cnt = 0;
        start_prog(5'd4);
        run(3, 6, -1, 5'd0, 1'b0);
        chk_out = 1'b0;
`ifdef SHADER_IF_PERF_EN
        check_eq("perf_fetch", 64'(oPerfFetchCnt), 64'd4);
        check_eq("perf_stall", 64'(oPerfStallCnt), 64'd4);
`endif

        // Branch while B presented
        push_exp(5'd4, W_A); push_exp(5'd5, W_B); push_exp(5'd20, W_D); push_exp(5'd21, W_END2);
        start_prog(5'd4);
        run(0, -1, 3, 5'd20, 1'b0);

        // PC wrap
        push_exp(5'd31, W_X); push_exp(5'd0, W_END3);
        start_prog(5'd31);
        run(0, -1, -1, 5'd0, 1'b0);

        // Reset mid-run with two words buffered
        iReady = 1'b0;
        start_prog(5'd4);
        repeat (4) @(posedge clk);
        #1;
        check_eq("pre_rst_valid", 64'(oValid), 64'd1);
        check_eq("pre_rst_busy", 64'(oBusy), 64'd1);
        resetn = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(oValid), 64'd0);
        check_eq("midrst_busy", 64'(oBusy), 64'd0);
        check_eq("midrst_rd", 64'(oIMemRd), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        iReady = 1'b1;
        push_exp(5'd20, W_D); push_exp(5'd21, W_END2);
        start_prog(5'd20);
        run(0, -1, -1, 5'd0, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
